serial_swan256_dec_key_precompute: RTL

//  Iterative pre-computation engine for SWAN256 decryption. Runs the forward key

---
 rtl/serial_swan256_dec_key_precompute.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_swan256_dec_key_precompute.sv
// Iterative SWAN256 forward key-schedule engine feeding the serial decryption core.
// Optional macro SWAN_KS_2STEP_EN chains two schedule steps per clock.
module serial_swan256_dec_key_precompute #(
  parameter int unsigned KEY_SIZE    = 256,
  parameter int unsigned SIDE_SIZE   = 128,
  parameter int unsigned PD          = 120,
  parameter logic [0:SIDE_SIZE-1] DELTA0 = 128'h9e3779b97f4a7c15f39cc0605cedc834,
  parameter int unsigned HALF_ROUNDS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [0:KEY_SIZE-1]   key,
  output logic                  busy,
  output logic                  done,
  output logic [0:KEY_SIZE-1]   key_out,
  output logic [0:SIDE_SIZE-1]  rd_out
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [7:0] HrCnt = 8'(HALF_ROUNDS);
`ifdef SWAN_KS_2STEP_EN
  localparam logic [7:0] StepN = 8'd2;
`else
  localparam logic [7:0] StepN = 8'd1;
`endif

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [0:KEY_SIZE-1]   key_q, key_d;
  logic [0:SIDE_SIZE-1]  rd_q, rd_d;
  logic                  done_q, done_d;

  logic [0:KEY_SIZE-1]   key_nx;
  logic [0:SIDE_SIZE-1]  rd_nx;

  // First schedule step: rotate right by PD, then add the new delta into the low half.
  logic [0:SIDE_SIZE-1]  rd1, lo1;
  logic [0:KEY_SIZE-1]   rot1, k1;

  assign rd1  = rd_q + DELTA0;
  assign rot1 = {key_q[KEY_SIZE-PD:KEY_SIZE-1], key_q[0:KEY_SIZE-1-PD]};
  assign lo1  = rot1[KEY_SIZE-SIDE_SIZE:KEY_SIZE-1] + rd1;
  assign k1   = {rot1[0:KEY_SIZE-SIDE_SIZE-1], lo1};

`ifdef SWAN_KS_2STEP_EN
  logic [0:SIDE_SIZE-1]  rd2, lo2;
  logic [0:KEY_SIZE-1]   rot2, k2;

  assign rd2  = rd1 + DELTA0;
  assign rot2 = {k1[KEY_SIZE-PD:KEY_SIZE-1], k1[0:KEY_SIZE-1-PD]};
  assign lo2  = rot2[KEY_SIZE-SIDE_SIZE:KEY_SIZE-1] + rd2;
  assign k2   = {rot2[0:KEY_SIZE-SIDE_SIZE-1], lo2};

  assign key_nx = k2;
  assign rd_nx  = rd2;
`else
  assign key_nx = k1;
  assign rd_nx  = rd1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    // A start in any state (including mid-run) restarts from the new key.
    if (start) begin
      state_d = StRun;
      cnt_d   = HrCnt;
      key_d   = key;
      rd_d    = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          key_d = key_nx;
          rd_d  = rd_nx;
          cnt_d = cnt_q - StepN;
          if (cnt_q <= StepN) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      key_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = done_q;
  assign key_out = key_q;
  assign rd_out  = rd_q;

endmodule
